// File: rtl/wb_arb_pkg.sv
// Shared types and grant encodings for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_ack_watchdog.sv
// Counts stalled strobe cycles and emits a one-cycle timeout pulse when the
// slave fails to acknowledge within TIMEOUT_CYCLES; TIMEOUT_CYCLES = 0 disables it.
module wb_ack_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TIMEOUT_WIDTH  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    input  logic ack,
    input  logic clear,
    output logic timeout
);

    localparam bit                     ENABLED = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] LAST  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_WIDTH-1:0] count_q;
    logic                     pulse_q;
    logic                     hit;

    // The pulse cycle itself never counts, so errors are spaced a full window apart.
    assign hit = ENABLED && !clear && stb && !ack && !pulse_q && (count_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= hit;
            if (clear || !stb || ack || pulse_q || hit) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + TIMEOUT_WIDTH'(1);
            end
        end
    end

    assign timeout = pulse_q;

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Round-robin two-master to one-slave Wishbone classic arbiter with bus lock
// for the duration of the granted master's cyc and an ack-timeout watchdog.
module wb_dual_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TIMEOUT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_ack_i,
    output logic [1:0]            grant_o
);

    arb_state_t state_q, state_d;
    logic       last_m1_q, last_m1_d;
    logic       req0, req1;
    logic       wd_stb, wd_clear, timeout;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_m1_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_m1_q <= last_m1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_m1_d = last_m1_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && (!req1 || last_m1_q)) begin
                    state_d = GRANT0;
                end else if (req1) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (!m0_cyc_i) begin
                    state_d   = IDLE;
                    last_m1_d = 1'b0;
                end
            end
            GRANT1: begin
                if (!m1_cyc_i) begin
                    state_d   = IDLE;
                    last_m1_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_data_o  = '0;
        m0_data_o = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_data_o = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        grant_o   = GRANT_NONE;
        wd_stb    = 1'b0;
        wd_clear  = 1'b1;
        unique case (state_q)
            GRANT0: begin
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = m0_stb_i & ~timeout;
                s_we_o    = m0_we_i;
                s_addr_o  = m0_addr_i;
                s_data_o  = m0_data_i;
                m0_data_o = s_data_i;
                m0_ack_o  = s_ack_i;
                m0_err_o  = timeout;
                grant_o   = GRANT_M0;
                wd_stb    = m0_stb_i;
                wd_clear  = ~m0_cyc_i;
            end
            GRANT1: begin
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = m1_stb_i & ~timeout;
                s_we_o    = m1_we_i;
                s_addr_o  = m1_addr_i;
                s_data_o  = m1_data_i;
                m1_data_o = s_data_i;
                m1_ack_o  = s_ack_i;
                m1_err_o  = timeout;
                grant_o   = GRANT_M1;
                wd_stb    = m1_stb_i;
                wd_clear  = ~m1_cyc_i;
            end
            default: ;
        endcase
    end

    wb_ack_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .stb     (wd_stb),
        .ack     (s_ack_i),
        .clear   (wd_clear),
        .timeout (timeout)
    );

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Directed bench for wb_dual_master_arbiter: a cycle-level ownership model is
// compared every cycle, plus hand-computed literal expectations per scenario.
module tb_wb_dual_master_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TC = 8;
    localparam int unsigned TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we, s_ack;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [1:0]    grant;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_dual_master_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TC),
        .TIMEOUT_WIDTH  (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_cyc_i  (m0_cyc),
        .m0_stb_i  (m0_stb),
        .m0_we_i   (m0_we),
        .m0_addr_i (m0_addr),
        .m0_data_i (m0_wdata),
        .m0_data_o (m0_rdata),
        .m0_ack_o  (m0_ack),
        .m0_err_o  (m0_err),
        .m1_cyc_i  (m1_cyc),
        .m1_stb_i  (m1_stb),
        .m1_we_i   (m1_we),
        .m1_addr_i (m1_addr),
        .m1_data_i (m1_wdata),
        .m1_data_o (m1_rdata),
        .m1_ack_o  (m1_ack),
        .m1_err_o  (m1_err),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_addr_o  (s_addr),
        .s_data_o  (s_wdata),
        .s_data_i  (s_rdata),
        .s_ack_i   (s_ack),
        .grant_o   (grant)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: owner (0 none, 1 = m0, 2 = m1), who released last, stalled strobe count, error pending.
    int owner = 0;
    int last_owner = 2;
    int stall = 0;
    bit err_pending = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int  n_owner, n_last, n_stall;
        bit  n_err, cyc, stb;
        if (!rst_n) begin
            owner       <= 0;
            last_owner  <= 2;
            stall       <= 0;
            err_pending <= 1'b0;
        end else begin
            n_owner = owner;
            n_last  = last_owner;
            n_stall = 0;
            n_err   = 1'b0;
            if (owner == 0) begin
                if (m0_cyc && m0_stb && m1_cyc && m1_stb) n_owner = (last_owner == 2) ? 1 : 2;
                else if (m0_cyc && m0_stb)                n_owner = 1;
                else if (m1_cyc && m1_stb)                n_owner = 2;
            end else begin
                cyc = (owner == 1) ? m0_cyc : m1_cyc;
                stb = (owner == 1) ? m0_stb : m1_stb;
                if (!cyc) begin
                    n_owner = 0;
                    n_last  = owner;
                end else if (!err_pending && stb && !s_ack) begin
                    if (stall == int'(TC) - 1) n_err = 1'b1;
                    else                       n_stall = stall + 1;
                end
            end
            owner       <= n_owner;
            last_owner  <= n_last;
            stall       <= n_stall;
            err_pending <= n_err;
        end
    end

    always @(negedge clk) begin : compare
        logic own0, own1;
        own0 = (owner == 1);
        own1 = (owner == 2);
        check("grant",   grant, {own1, own0});
        check("s_cyc",   s_cyc, own0 ? m0_cyc : own1 ? m1_cyc : 1'b0);
        check("s_stb",   s_stb, (own0 ? m0_stb : own1 ? m1_stb : 1'b0) & ~err_pending);
        check("s_we",    s_we,  own0 ? m0_we : own1 ? m1_we : 1'b0);
        check("s_addr",  s_addr,  own0 ? m0_addr : own1 ? m1_addr : '0);
        check("s_data",  s_wdata, own0 ? m0_wdata : own1 ? m1_wdata : '0);
        check("m0_ack",  m0_ack, own0 & s_ack);
        check("m1_ack",  m1_ack, own1 & s_ack);
        check("m0_err",  m0_err, own0 & err_pending);
        check("m1_err",  m1_err, own1 & err_pending);
        check("m0_data", m0_rdata, own0 ? s_rdata : '0);
        check("m1_data", m1_rdata, own1 ? s_rdata : '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        s_ack = 1'b0;  s_rdata = '0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        reset_dut();

        // Single m0 read acked on the third granted cycle
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h0000_0010;
        settle();
        check("t1_idle_grant", grant, 2'b00);
        check("t1_reset_scyc", s_cyc, 1'b0);
        tick(); settle();
        check("t1_grant", grant, 2'b01);
        check("t1_addr", s_addr, 32'h0000_0010);
        check("t1_stb", s_stb, 1'b1);
        tick(); tick();
        s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF;
        settle();
        check("t1_ack", m0_ack, 1'b1);
        check("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("t1_m1_ack", m1_ack, 1'b0);
        tick();
        s_ack = 1'b0; s_rdata = '0; m0_cyc = 1'b0; m0_stb = 1'b0;
        settle();
        check("t1_ack_once", m0_ack, 1'b0);
        tick(); settle();
        check("t1_release", grant, 2'b00);

        // Tie after reset goes to m0, then one idle cycle, then m1; next tie to m0 again
        reset_dut();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h100;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h200;
        tick(); settle();
        check("t2_first", grant, 2'b01);
        check("t2_addr0", s_addr, 32'h100);
        tick(); s_ack = 1'b1;
        settle();
        check("t2_m0_ack", m0_ack, 1'b1);
        check("t2_m1_noack", m1_ack, 1'b0);
        tick(); s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        settle();
        check("t2_hold", grant, 2'b01);
        tick(); s_ack = 1'b1;
        settle();
        check("t2_gap", grant, 2'b00);
        check("t2_idle_ack0", m0_ack, 1'b0);
        check("t2_idle_ack1", m1_ack, 1'b0);
        tick(); s_ack = 1'b0;
        settle();
        check("t2_second", grant, 2'b10);
        check("t2_addr1", s_addr, 32'h200);
        tick(); s_ack = 1'b1;
        settle();
        check("t2_m1_ack", m1_ack, 1'b1);
        tick(); s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        settle();
        check("t2_gap2", grant, 2'b00);
        tick(); settle();
        check("t2_rr_m0", grant, 2'b01);
        tick(); m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();

        // m1 write waits while m0 locks the bus across two acked reads
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h20;
        tick();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
        m1_addr = 32'h8000_0000; m1_wdata = 32'h1234_5678;
        s_ack = 1'b1; s_rdata = 32'hA5A5_0001;
        settle();
        check("t3_m0_owns", grant, 2'b01);
        check("t3_we0", s_we, 1'b0);
        check("t3_rd1", m0_rdata, 32'hA5A5_0001);
        check("t3_m1_wait", m1_ack, 1'b0);
        tick(); s_ack = 1'b0; m0_stb = 1'b0;
        settle();
        check("t3_lock", grant, 2'b01);
        check("t3_lock_cyc", s_cyc, 1'b1);
        tick(); m0_stb = 1'b1; m0_addr = 32'h24; s_ack = 1'b1; s_rdata = 32'hA5A5_0002;
        settle();
        check("t3_addr2", s_addr, 32'h24);
        check("t3_we2", s_we, 1'b0);
        tick(); s_ack = 1'b0; s_rdata = '0; m0_cyc = 1'b0; m0_stb = 1'b0;
        tick(); settle();
        check("t3_gap", grant, 2'b00);
        check("t3_gap_we", s_we, 1'b0);
        tick(); settle();
        check("t3_m1_grant", grant, 2'b10);
        check("t3_we", s_we, 1'b1);
        check("t3_wdata", s_wdata, 32'h1234_5678);
        check("t3_waddr", s_addr, 32'h8000_0000);
        check("t3_stb_rise", s_stb, 1'b1);

        // Slave never acks: err on the eighth cycle after stb rose
        for (int k = 1; k <= 7; k++) begin
            tick(); settle();
            check("t4_no_err", m1_err, 1'b0);
            check("t4_stb", s_stb, 1'b1);
        end
        tick(); settle();
        check("t4_err", m1_err, 1'b1);
        check("t4_stb_forced", s_stb, 1'b0);
        check("t4_grant_kept", grant, 2'b10);
        check("t4_m0_err", m0_err, 1'b0);

        // Ack arrives on the cycle the count reaches the limit: ack wins
        for (int k = 9; k <= 15; k++) begin
            tick(); settle();
            check("t5_no_err", m1_err, 1'b0);
        end
        tick(); s_ack = 1'b1; s_rdata = 32'hCAFE_0000;
        settle();
        check("t5_ack", m1_ack, 1'b1);
        check("t5_ack_err", m1_err, 1'b0);
        check("t5_ack_data", m1_rdata, 32'hCAFE_0000);
        tick(); s_ack = 1'b0; s_rdata = '0;
        settle();
        check("t5_err_after", m1_err, 1'b0);
        check("t5_stb_after", s_stb, 1'b1);

        // Asynchronous reset mid-transaction, then tie resolves to m0
        #2 rst_n = 1'b0;
        #1;
        check("t6_cyc", s_cyc, 1'b0);
        check("t6_stb", s_stb, 1'b0);
        check("t6_grant", grant, 2'b00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h40;
        tick(); settle();
        check("t6_tie_m0", grant, 2'b01);
        tick(); idle_inputs();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_dual_master_arbiter.md
Name: wb_dual_master_arbiter

Overview:
- Two-master to one-slave Wishbone classic arbiter.
- Sits directly upstream of the Controller core bus (core_cyc/stb/we/addr/data/ack).
- Lets a core with split instruction and data ports share the single Controller bus when ENABLE_SECOND_MEMORY is off.
- Provides round-robin fairness, bus lock for the duration of a master's cyc, and an ack-timeout watchdog that returns err instead of hanging the core.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- TIMEOUT_CYCLES, 1024, cycles with stb high and no ack before err is raised; 0 disables the watchdog.
- TIMEOUT_WIDTH, 16, counter width; must satisfy TIMEOUT_CYCLES < 2**TIMEOUT_WIDTH.

Ports:
- clk  input  1  core clock; single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- m0_cyc_i  input  1  master 0 (instruction) cycle.
- m0_stb_i  input  1  master 0 strobe.
- m0_we_i  input  1  master 0 write enable.
- m0_addr_i  input  ADDR_WIDTH  master 0 address.
- m0_data_i  input  DATA_WIDTH  master 0 write data.
- m0_data_o  output  DATA_WIDTH  master 0 read data.
- m0_ack_o  output  1  master 0 acknowledge.
- m0_err_o  output  1  master 0 timeout error.
- m1_*  as m0_*  master 1 (data), identical set.
- s_cyc_o  output  1  slave cycle.
- s_stb_o  output  1  slave strobe.
- s_we_o  output  1  slave write enable.
- s_addr_o  output  ADDR_WIDTH  slave address.
- s_data_o  output  DATA_WIDTH  slave write data.
- s_data_i  input  DATA_WIDTH  slave read data.
- s_ack_i  input  1  slave acknowledge.
- grant_o  output  2  one-hot current grant (bit0 = m0, bit1 = m1); 00 when idle.

Behaviour:
Reset:
- Asynchronous, active-low.
- State IDLE; grant_o = 00; last_grant = m1, so m0 wins the first tie.
- Timeout counter = 0.
- All s_* outputs, m*_ack_o, m*_err_o = 0; m*_data_o = 0 in IDLE.

States:
- IDLE: no master is granted. A master requests when cyc_i & stb_i.
  - Only m0 requests -> GRANT0 next cycle.
  - Only m1 requests -> GRANT1 next cycle.
  - Both request -> grant the master that is not last_grant.
  - Arbitration latency is exactly 1 cycle: the request is sampled in IDLE and the slave sees stb on the next edge.
- GRANT0 / GRANT1:
  - s_cyc_o/s_stb_o/s_we_o/s_addr_o/s_data_o are driven combinationally from the granted master.
  - s_ack_i and s_data_i route combinationally to the granted master.
  - The non-granted master sees ack = 0, err = 0, data = 0.
  - The grant holds while the granted master's cyc_i = 1 (bus lock for back-to-back or RMW).
  - Granted cyc_i falls -> IDLE next cycle and last_grant is updated. One idle cycle always follows a release; there is no same-cycle handoff.

Watchdog (TIMEOUT_CYCLES != 0):
- In a GRANT state, the counter increments each cycle with granted stb = 1 and s_ack_i = 0.
- The counter clears on ack, on stb low, or on leaving the state.
- When the counter reaches TIMEOUT_CYCLES-1 with no ack:
  - The next cycle drives err_o = 1 to the granted master for exactly one cycle.
  - s_stb_o is forced to 0 in that cycle and the counter clears.
  - The grant is retained; the master decides whether to drop cyc.
- ack and timeout in the same cycle: ack wins; no err.

Simultaneous and boundary cases:
- Only the granted master's strobe reaches the slave. A request that arrives while the other master holds the bus waits; it is never dropped.
- s_ack_i while IDLE is ignored; no master sees it.
- Reset asserted mid-transaction: all outputs go to their reset values immediately (async). A pending slave ack is discarded.

Decomposition:
- Package wb_arb_pkg holds:
  - Enum arb_state_t {IDLE, GRANT0, GRANT1}.
  - Grant encodings GRANT_NONE = 2'b00, GRANT_M0 = 2'b01, GRANT_M1 = 2'b10.
- Sub-module wb_ack_watchdog: counter, compare, and one-cycle err pulse. Parameterised by TIMEOUT_CYCLES/TIMEOUT_WIDTH; inputs stb, ack, clear; output timeout pulse.
- Arbiter FSM and muxes stay in the top module.

Test Plan:
- m0 read at 0x00000010, slave acks in 3 cycles with 0xDEADBEEF -> grant_o = 01 one cycle after the request; s_addr_o = 0x10; m0_data_o = 0xDEADBEEF with m0_ack_o for 1 cycle; m1_ack_o stays 0.
- m0 and m1 both request in the same cycle after reset -> m0 is granted first. After m0 drops cyc, one idle cycle, then m1 is granted. Repeat with both requesting -> m0 again (last_grant = m1).
- m1 write 0x12345678 to 0x80000000 while m0 holds cyc across two acked reads -> m1 waits. s_we_o = 1 with s_data_o = 0x12345678 only after m0 releases.
- TIMEOUT_CYCLES = 8, slave never acks m1 -> m1_err_o = 1 on exactly one cycle, 8 cycles after s_stb_o first rose. s_stb_o = 0 on that cycle; grant_o stays 10.
- Slave acks on the same cycle the counter reaches 7 -> m*_ack_o = 1 and err stays 0.
- rst_n pulsed low mid-transaction with stb high -> s_cyc_o/s_stb_o = 0 and grant_o = 00 asynchronously. After release, the first tie goes to m0.
